hdc_text_sequencer: RTL and testbench
=====================================

# hdc_text_sequencer

Control block between the character source and the HDC encode/classify datapath of the spam/ham classifier. Buffers one text message of up to MAX_LEN 32-bit characters, replays it to the tokenizer/encoder one character per handshake, triggers the classifier once the message is fully encoded, and returns the ham/spam verdict with the message length. Only one message is in flight at a time; the block serialises message load, encode, classify and report.

## Interface
- CHAR_W, 32, width of one character
- MAX_LEN, 160, buffer depth in characters
- LEN_W, 8, width of length counters and res_len; must hold MAX_LEN
- CLS_TIMEOUT, 1024, classifier watchdog limit in cycles; used only with HDC_SEQ_TIMEOUT_EN
- clk  in  1  clock, all logic on rising edge
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  source character valid
- in_ready  out  1  block accepts a character
- in_char  in  CHAR_W  character data
- in_last  in  1  marks the final character of a message
- enc_valid  out  1  character presented to encoder
- enc_ready  in  1  encoder accepts character
- enc_char  out  CHAR_W  character to encoder
- enc_first  out  1  enc_char is character 0 of the message
- enc_last  out  1  enc_char is the final buffered character
- cls_start  out  1  one-cycle classify request
- cls_done  in  1  classifier finished
- cls_spam  in  1  classifier verdict, valid with cls_done
- res_valid  out  1  result available
- res_ready  in  1  consumer accepts result
- res_spam  out  1  1 = spam, 0 = ham
- res_len  out  LEN_W  number of characters encoded
- res_overflow  out  1  message exceeded MAX_LEN
- res_timeout  out  1  classifier watchdog fired
- busy  out  1  state is not LOAD

## Operation
- States: LOAD, EMIT, START, WAIT, REPORT.
- LOAD: in_ready=1. Each in_valid&&in_ready writes in_char at wr_idx while wr_idx<MAX_LEN; wr_idx saturates at MAX_LEN. Characters beyond MAX_LEN are accepted and discarded, and the overflow flag is set. A handshake with in_last=1 moves to EMIT; length = min(count, MAX_LEN).
- Every message has at least one character (in_last travels with a character).
- EMIT: enc_valid=1, enc_char=buf[rd_idx], enc_first=(rd_idx==0), enc_last=(rd_idx==len-1). Advance on enc_valid&&enc_ready. enc_char stays stable while stalled. The handshake with enc_last moves to START.
- START: cls_start=1 for exactly one cycle, then WAIT. A cls_done asserted during START is ignored.
- WAIT: on cls_done, latch cls_spam into res_spam and move to REPORT.
- REPORT: res_valid=1; res_spam, res_len, res_overflow and res_timeout are held stable. On res_ready, move to LOAD and clear wr_idx, rd_idx, overflow and timeout.
- in_ready=0 in every state except LOAD. in_valid outside LOAD is not consumed.
- Buffer contents are not cleared; only the indices reset.

## Timing
- Reset values: state LOAD, in_ready=1, and every other output 0 (including busy, all res_* and enc_*).
- Reset mid-operation (any state) aborts the message: no cls_start and no res_valid for it.
- Last in_last handshake at cycle t: enc_valid=1 at t+1.
- With enc_ready held high, an N-character message gives enc_valid for cycles t+1..t+N, cls_start at t+N+1, and WAIT from t+N+2.
- cls_done sampled in WAIT at cycle u: res_valid=1 at u+1.
- res_ready handshake at cycle v: in_ready=1 at v+1. Back-to-back messages therefore have a one-cycle gap.

## Configuration
- HDC_SEQ_TIMEOUT_EN defined: a counter runs in WAIT. If CLS_TIMEOUT cycles pass without cls_done, the block enters REPORT with res_timeout=1 and res_spam=0. A cls_done arriving later, in REPORT or LOAD, is ignored.
- HDC_SEQ_TIMEOUT_EN undefined: WAIT holds indefinitely, res_timeout is tied 0, and no counter is built.

## Test plan
- Message of 5 chars 0x61..0x65, enc_ready=1, cls_done with cls_spam=1 three cycles after cls_start -> enc_char sequence 0x61..0x65 with enc_first on the first and enc_last on the fifth; res_valid with res_spam=1, res_len=5, res_overflow=0.
- 1-char message with enc_ready toggling 0,0,1 -> enc_valid held 3 cycles with enc_char stable and enc_first=enc_last=1; one cls_start; res_len=1.
- 170-char message -> in_ready stays 1 for all 170; 160 encoder handshakes; res_len=160, res_overflow=1.
- Reset asserted for one cycle mid-EMIT after 2 of 4 chars -> next cycle in_ready=1, busy=0, no cls_start; the next 3-char message reports res_len=3.
- res_ready held 0 for 10 cycles in REPORT -> res_* stable and in_ready=0 throughout; in_ready=1 the cycle after the res_ready handshake.
- With HDC_SEQ_TIMEOUT_EN, CLS_TIMEOUT=16 and cls_done never asserted -> res_valid 17 cycles after cls_start with res_timeout=1 and res_spam=0. Without the macro, res_valid stays 0 for 2000 cycles.

Source files
------------

// File: rtl/hdc_text_sequencer.sv
// Message sequencer for the HDC spam/ham classifier: load, replay to encoder, classify, report.
// Optional classifier watchdog enabled by defining HDC_SEQ_TIMEOUT_EN.
module hdc_text_sequencer #(
    parameter int CHAR_W  = 32,
    parameter int MAX_LEN = 160,
    parameter int LEN_W   = 8
`ifdef HDC_SEQ_TIMEOUT_EN
    ,
    parameter int CLS_TIMEOUT = 1024
`endif
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [CHAR_W-1:0] in_char,
    input  logic              in_last,
    output logic              enc_valid,
    input  logic              enc_ready,
    output logic [CHAR_W-1:0] enc_char,
    output logic              enc_first,
    output logic              enc_last,
    output logic              cls_start,
    input  logic              cls_done,
    input  logic              cls_spam,
    output logic              res_valid,
    input  logic              res_ready,
    output logic              res_spam,
    output logic [LEN_W-1:0]  res_len,
    output logic              res_overflow,
    output logic              res_timeout,
    output logic              busy
);

    typedef enum logic [2:0] {
        S_LOAD,
        S_EMIT,
        S_START,
        S_WAIT,
        S_REPORT
    } state_t;

    localparam logic [LEN_W-1:0] LEN_MAX = LEN_W'(MAX_LEN);

    state_t            r_state;
    state_t            w_next;
    logic [CHAR_W-1:0] r_buf [MAX_LEN];
    logic [LEN_W-1:0]  r_wr_idx;
    logic [LEN_W-1:0]  r_rd_idx;
    logic [LEN_W-1:0]  r_len;
    logic              r_overflow;
    logic              r_spam;
    logic              r_timeout;
    logic              w_wr_room;
    logic              w_rd_last;
    logic              w_tmo_fire;

    assign w_wr_room = (r_wr_idx < LEN_MAX);
    assign w_rd_last = (r_rd_idx == r_len - LEN_W'(1));

`ifdef HDC_SEQ_TIMEOUT_EN
    localparam int TMO_W = $clog2(CLS_TIMEOUT + 1);

    logic [TMO_W-1:0] r_tmo_cnt;

    always_ff @(posedge clk) begin
        if (reset || r_state != S_WAIT) begin
            r_tmo_cnt <= '0;
        end else begin
            r_tmo_cnt <= r_tmo_cnt + TMO_W'(1);
        end
    end

    // Fires on the CLS_TIMEOUT-th WAIT cycle; a same-cycle cls_done wins.
    assign w_tmo_fire = (r_state == S_WAIT) && !cls_done &&
                        (r_tmo_cnt == TMO_W'(CLS_TIMEOUT - 1));
`else
    assign w_tmo_fire = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_LOAD;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        // NOTE: every output of this block gets a default first so no path leaves one unassigned (no latch).
        w_next    = r_state;
        in_ready  = 1'b0;
        enc_valid = 1'b0;
        cls_start = 1'b0;
        res_valid = 1'b0;
        case (r_state)
            S_LOAD: begin
                in_ready = 1'b1;
                if (in_valid && in_last) w_next = S_EMIT;
            end
            S_EMIT: begin
                enc_valid = 1'b1;
                if (enc_ready && w_rd_last) w_next = S_START;
            end
            S_START: begin
                cls_start = 1'b1;
                w_next    = S_WAIT;
            end
            S_WAIT: begin
                if (cls_done || w_tmo_fire) w_next = S_REPORT;
            end
            S_REPORT: begin
                res_valid = 1'b1;
                if (res_ready) w_next = S_LOAD;
            end
            default: w_next = S_LOAD;
        endcase
    end

    // NOTE: the message buffer is deliberately not reset; only the indices are, so it maps to plain RAM.
    always_ff @(posedge clk) begin
        if (r_state == S_LOAD && in_valid && w_wr_room) begin
            r_buf[r_wr_idx] <= in_char;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_idx   <= '0;
            r_rd_idx   <= '0;
            r_len      <= '0;
            r_overflow <= 1'b0;
            r_spam     <= 1'b0;
            r_timeout  <= 1'b0;
        end else begin
            case (r_state)
                S_LOAD: begin
                    if (in_valid) begin
                        if (w_wr_room) begin
                            r_wr_idx <= r_wr_idx + LEN_W'(1);
                        end else begin
                            r_overflow <= 1'b1;
                        end
                        if (in_last) begin
                            r_len    <= w_wr_room ? r_wr_idx + LEN_W'(1) : LEN_MAX;
                            r_rd_idx <= '0;
                        end
                    end
                end
                S_EMIT: begin
                    if (enc_ready) r_rd_idx <= r_rd_idx + LEN_W'(1);
                end
                S_WAIT: begin
                    if (cls_done) begin
                        r_spam    <= cls_spam;
                        r_timeout <= 1'b0;
                    end else if (w_tmo_fire) begin
                        r_spam    <= 1'b0;
                        r_timeout <= 1'b1;
                    end
                end
                S_REPORT: begin
                    if (res_ready) begin
                        r_wr_idx   <= '0;
                        r_rd_idx   <= '0;
                        r_overflow <= 1'b0;
                        r_timeout  <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    // Data outputs are forced to zero outside the state that qualifies them.
    assign enc_char     = enc_valid ? r_buf[r_rd_idx] : '0;
    assign enc_first    = enc_valid && (r_rd_idx == '0);
    assign enc_last     = enc_valid && w_rd_last;
    assign res_spam     = res_valid && r_spam;
    assign res_len      = res_valid ? r_len : '0;
    assign res_overflow = res_valid && r_overflow;
    assign res_timeout  = res_valid && r_timeout;
    assign busy         = (r_state != S_LOAD);

endmodule

// File: tb/tb_hdc_text_sequencer.sv
// Directed, scoreboard-checked bench for hdc_text_sequencer (honours HDC_SEQ_TIMEOUT_EN).
module tb_hdc_text_sequencer;

    localparam int CHAR_W  = 32;
    localparam int MAX_LEN = 160;
    localparam int LEN_W   = 8;

    typedef struct packed {
        logic             spam;
        logic [LEN_W-1:0] len;
        logic             ovf;
        logic             tmo;
    } res_t;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [CHAR_W-1:0] in_char = '0;
    logic              in_last = 1'b0;
    logic              enc_valid;
    logic              enc_ready = 1'b0;
    logic [CHAR_W-1:0] enc_char;
    logic              enc_first;
    logic              enc_last;
    logic              cls_start;
    logic              cls_done = 1'b0;
    logic              cls_spam = 1'b0;
    logic              res_valid;
    logic              res_ready = 1'b0;
    logic              res_spam;
    logic [LEN_W-1:0]  res_len;
    logic              res_overflow;
    logic              res_timeout;
    logic              busy;

    res_t              res_q [$];
    logic [CHAR_W-1:0] enc_q [$];
    int                n_vec = 0;
    int                n_err = 0;
    int                n_start = 0;

    hdc_text_sequencer #(
        .CHAR_W (CHAR_W),
        .MAX_LEN(MAX_LEN),
        .LEN_W  (LEN_W)
`ifdef HDC_SEQ_TIMEOUT_EN
        ,
        .CLS_TIMEOUT(16)
`endif
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_char     (in_char),
        .in_last     (in_last),
        .enc_valid   (enc_valid),
        .enc_ready   (enc_ready),
        .enc_char    (enc_char),
        .enc_first   (enc_first),
        .enc_last    (enc_last),
        .cls_start   (cls_start),
        .cls_done    (cls_done),
        .cls_spam    (cls_spam),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .res_spam    (res_spam),
        .res_len     (res_len),
        .res_overflow(res_overflow),
        .res_timeout (res_timeout),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (cls_start) n_start <= n_start + 1;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic send_msg(input int n, input logic [CHAR_W-1:0] base);
        for (int i = 0; i < n; i++) begin
            in_valid = 1'b1;
            in_char  = base + CHAR_W'(i);
            in_last  = (i == n - 1);
            check($sformatf("in_ready[%0d]", i), in_ready, 1);
            if (i < MAX_LEN) enc_q.push_back(base + CHAR_W'(i));
            tick();
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic expect_enc(input int n, input int total);
        enc_ready = 1'b1;
        for (int k = 0; k < n; k++) begin
            logic [CHAR_W-1:0] e;
            e = enc_q.pop_front();
            check($sformatf("enc_valid[%0d]", k), enc_valid, 1);
            check($sformatf("enc_char[%0d]", k), enc_char, e);
            check($sformatf("enc_first[%0d]", k), enc_first, k == 0);
            check($sformatf("enc_last[%0d]", k), enc_last, k == total - 1);
            tick();
        end
    endtask

    task automatic expect_start();
        check("cls_start", cls_start, 1);
        check("enc_valid_off", enc_valid, 0);
        tick();
        check("cls_start_once", cls_start, 0);
        check("busy_wait", busy, 1);
    endtask

    task automatic expect_result(input int hold);
        res_t e;
        int   guard;
        guard = 0;
        while (!res_valid && guard < 3000) begin
            tick();
            guard++;
        end
        check("res_valid", res_valid, 1);
        e = res_q.pop_front();
        for (int c = 0; c <= hold; c++) begin
            check($sformatf("res_spam[%0d]", c), res_spam, e.spam);
            check($sformatf("res_len[%0d]", c), res_len, e.len);
            check($sformatf("res_overflow[%0d]", c), res_overflow, e.ovf);
            check($sformatf("res_timeout[%0d]", c), res_timeout, e.tmo);
            check($sformatf("in_ready_report[%0d]", c), in_ready, 0);
            if (c < hold) tick();
        end
        res_ready = 1'b1;
        tick();
        res_ready = 1'b0;
        check("in_ready_after_res", in_ready, 1);
        check("res_valid_clear", res_valid, 0);
    endtask

    initial begin
        int   starts;
        int   cnt;
        logic seen;

        // Reset state
        repeat (2) tick();
        reset = 1'b0;
        check("rst_in_ready", in_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_enc", {enc_valid, enc_first, enc_last, enc_char}, 0);
        check("rst_cls_start", cls_start, 0);
        check("rst_res", {res_valid, res_spam, res_len, res_overflow, res_timeout}, 0);

        // Five-character spam message, long result stall
        res_q.push_back('{spam: 1'b1, len: 8'd5, ovf: 1'b0, tmo: 1'b0});
        send_msg(5, 32'h61);
        expect_enc(5, 5);
        expect_start();
        tick();
        tick();
        cls_done = 1'b1;
        cls_spam = 1'b1;
        tick();
        cls_done = 1'b0;
        cls_spam = 1'b0;
        check("res_latency", res_valid, 1);
        expect_result(10);

        // One character, encoder stalls twice, early cls_done in START is ignored
        enc_ready = 1'b0;
        send_msg(1, 32'h41);
        for (int k = 0; k < 3; k++) begin
            enc_ready = (k == 2);
            check($sformatf("stall_valid[%0d]", k), enc_valid, 1);
            check($sformatf("stall_char[%0d]", k), enc_char, 32'h41);
            check($sformatf("stall_first_last[%0d]", k), {enc_first, enc_last}, 2'b11);
            tick();
        end
        void'(enc_q.pop_front());
        starts   = n_start;
        cls_done = 1'b1;
        cls_spam = 1'b1;
        check("cls_start_1char", cls_start, 1);
        tick();
        cls_done = 1'b0;
        cls_spam = 1'b0;
        check("start_done_ignored", res_valid, 0);
        tick();
        check("still_waiting", {res_valid, busy}, 2'b01);
        check("single_start", n_start - starts, 1);
        cls_done = 1'b1;
        tick();
        cls_done = 1'b0;
        res_q.push_back('{spam: 1'b0, len: 8'd1, ovf: 1'b0, tmo: 1'b0});
        expect_result(0);

        // Overflow: 170 characters, 160 kept
        res_q.push_back('{spam: 1'b0, len: 8'd160, ovf: 1'b1, tmo: 1'b0});
        send_msg(170, 32'h1000);
        expect_enc(160, 160);
        expect_start();
        cls_done = 1'b1;
        tick();
        cls_done = 1'b0;
        expect_result(0);

        // Reset mid-EMIT aborts the message
        starts = n_start;
        send_msg(4, 32'h200);
        expect_enc(2, 4);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("abort_in_ready", in_ready, 1);
        check("abort_busy", busy, 0);
        check("abort_enc_valid", enc_valid, 0);
        repeat (5) tick();
        check("abort_no_start", n_start - starts, 0);
        check("abort_no_res", res_valid, 0);
        enc_q.delete();
        res_q.push_back('{spam: 1'b1, len: 8'd3, ovf: 1'b0, tmo: 1'b0});
        send_msg(3, 32'h300);
        expect_enc(3, 3);
        expect_start();
        cls_done = 1'b1;
        cls_spam = 1'b1;
        tick();
        cls_done = 1'b0;
        cls_spam = 1'b0;
        expect_result(0);

        // Classifier never answers
        send_msg(1, 32'h7a);
        expect_enc(1, 1);
`ifdef HDC_SEQ_TIMEOUT_EN
        check("tmo_cls_start", cls_start, 1);
        cnt = 0;
        while (!res_valid && cnt < 100) begin
            tick();
            cnt++;
        end
        check("tmo_latency", cnt, 17);
        cls_done = 1'b1;
        cls_spam = 1'b1;
        res_q.push_back('{spam: 1'b0, len: 8'd1, ovf: 1'b0, tmo: 1'b1});
        expect_result(2);
        tick();
        cls_done = 1'b0;
        cls_spam = 1'b0;
        tick();
        check("late_done_ignored", {res_valid, busy, in_ready}, 3'b001);
`else
        expect_start();
        seen = 1'b0;
        repeat (2000) begin
            if (res_valid) seen = 1'b1;
            tick();
        end
        check("no_timeout_res", seen, 0);
        check("no_timeout_busy", busy, 1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("recover_in_ready", in_ready, 1);
`endif

        check("scoreboard_empty", res_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
